// File: rtl/stopwatch_display.sv
// Split/lap hold and 8-digit multiplexed 7-segment driver for the stopwatch.
// Shows hh.mm.ss.cc from the live BCD digits or from a frozen snapshot.
module stopwatch_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       split,
  input  logic [3:0] cent_0,
  input  logic [3:0] cent_1,
  input  logic [3:0] sec_0,
  input  logic [3:0] sec_1,
  input  logic [3:0] min_0,
  input  logic [3:0] min_1,
  input  logic [3:0] hr_0,
  input  logic [3:0] hr_1,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frozen
);

  localparam int unsigned NDIG = 8;
  localparam int unsigned DW   = 4;
  localparam int unsigned IW   = 3;
  localparam int unsigned SW   = 7;
  localparam int unsigned PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } mode_e;

  // Split button: two-flop synchroniser plus an edge flop.
  logic sync1_q, sync2_q, edge_q;
  logic split_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= split;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign split_pulse = sync2_q & ~edge_q;

  // Digit vector ordered by scan index: 0 = cent_0 (rightmost) .. 7 = hr_1.
  logic [NDIG-1:0][DW-1:0] live;
  assign live = {hr_1, hr_0, min_1, min_0, sec_1, sec_0, cent_1, cent_0};

  mode_e                   mode_q, mode_d;
  logic [NDIG-1:0][DW-1:0] snap_q, snap_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= LIVE;
      snap_q <= '0;
    end else begin
      mode_q <= mode_d;
      snap_q <= snap_d;
    end
  end

  // Each pulse toggles the hold; entering hold captures the live digits.
  always_comb begin
    mode_d = mode_q;
    snap_d = snap_q;
    case (mode_q)
      LIVE: begin
        if (split_pulse) begin
          mode_d = HELD;
          snap_d = live;
        end
      end
      HELD: begin
        if (split_pulse) begin
          mode_d = LIVE;
        end
      end
    endcase
  end

  assign frozen = (mode_q == HELD);

  // Scan prescaler and digit index; independent of the hold state.
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + IW'(1);
    end
  end

  function automatic logic [SW-1:0] decode(input logic [DW-1:0] d);
    logic [SW-1:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [DW-1:0]   digit_c;
  logic [NDIG-1:0] an_d;
  logic [SW-1:0]   seg_d;
  logic            dp_d;

  // Decimal points after hr_0, min_0 and sec_0 (even indices 2, 4, 6).
  always_comb begin
    digit_c = (mode_q == HELD) ? snap_q[idx_q] : live[idx_q];
    an_d    = ~(NDIG'(1) << idx_q);
    seg_d   = decode(digit_c);
    dp_d    = ~(~idx_q[0] & (|idx_q[2:1]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: decode table vectors, hand-written split/reset
// sequences and randomized traffic against a cycle-count based reference model.
module tb_stopwatch_display;

  localparam int unsigned RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       split = 1'b0;
  logic [3:0] dig [8];
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frozen;

  always #5 clk = ~clk;

  stopwatch_display #(.REFRESH_DIV(RD)) dut (
    .clk    (clk),
    .rst    (rst),
    .split  (split),
    .cent_0 (dig[0]),
    .cent_1 (dig[1]),
    .sec_0  (dig[2]),
    .sec_1  (dig[3]),
    .min_0  (dig[4]),
    .min_1  (dig[5]),
    .hr_0   (dig[6]),
    .hr_1   (dig[7]),
    .an     (an),
    .seg    (seg),
    .dp     (dp),
    .frozen (frozen)
  );

  typedef struct {
    logic [3:0] v;
    logic [6:0] seg;
  } vec_t;

  vec_t        vecs [16];
  logic [6:0]  dec_tab [16];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: edges since reset release, hold flag, snapshot, split history.
  int unsigned m_k;
  bit          m_frozen;
  logic [3:0]  m_snap [8];
  bit          hist [$];
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_frozen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int unsigned idx;
    int          n;
    bit          pulse;
    idx      = (m_k / RD) % 8;
    e_an     = ~(8'd1 << idx);
    e_seg    = dec_tab[m_frozen ? m_snap[idx] : dig[idx]];
    e_dp     = !(idx == 2 || idx == 4 || idx == 6);
    hist.push_back(split);
    n        = hist.size() - 1;
    // A level first seen at edge n-2 (low at n-3) is acted on at edge n.
    pulse    = (n >= 2 && hist[n-2]) && !(n >= 3 && hist[n-3]);
    if (pulse) begin
      if (!m_frozen) m_snap = dig;
      m_frozen = !m_frozen;
    end
    e_frozen = m_frozen;
    m_k++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frozen", 32'(frozen), 32'(e_frozen));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_an", 32'(an), 32'h FF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_frozen", 32'(frozen), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_k      = 0;
    m_frozen = 1'b0;
    foreach (m_snap[i]) m_snap[i] = 4'd0;
    hist.delete();
  endtask

  task automatic set_all(input logic [3:0] v);
    foreach (dig[i]) dig[i] = v;
  endtask

  initial begin
    logic [3:0] held [8];
    int         pos;
    logic [6:0] tab [16];

    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 16; i++) begin
      vecs[i].v   = 4'(i);
      vecs[i].seg = tab[i];
      dec_tab[i]  = tab[i];
    end
    set_all(4'd0);

    #2;
    do_reset();
    step();
    chk("first_an", 32'(an), 32'hFE);

    // Scan order across more than one frame.
    repeat (8 * RD + RD) step();

    // Decode vectors: every position shows the same value.
    for (int i = 0; i < 16; i++) begin
      set_all(vecs[i].v);
      step();
      chk("decode", 32'(seg), 32'(vecs[i].seg));
      repeat (8 * RD - 1) step();
    end

    // Freeze 12:34:56.78, then zero the live digits.
    dig = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    held = dig;
    repeat (3) step();
    split = 1'b1;
    step();
    split = 1'b0;
    step();
    chk("frozen_n1", 32'(frozen), 32'd0);
    step();
    chk("frozen_n2", 32'(frozen), 32'd1);
    set_all(4'd0);
    step();
    repeat (8 * RD) begin
      step();
      pos = 0;
      for (int p = 0; p < 8; p++) if (!an[p]) pos = p;
      chk("held_digit", 32'(seg), 32'(dec_tab[held[pos]]));
    end

    // Reset while frozen, mid-frame.
    repeat (3 * RD + 1) step();
    do_reset();
    repeat (8 * RD) step();

    // Long press toggles once; a second press unfreezes.
    dig = '{4'd9, 4'd1, 4'd0, 4'd2, 4'd5, 4'd3, 4'd2, 4'd0};
    split = 1'b1;
    repeat (50) step();
    split = 1'b0;
    repeat (5) step();
    chk("held_press", 32'(frozen), 32'd1);
    set_all(4'd7);
    split = 1'b1;
    repeat (2) step();
    split = 1'b0;
    repeat (3) step();
    chk("second_press", 32'(frozen), 32'd0);
    chk("live_again", 32'(seg), 32'h78);
    repeat (8 * RD) step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) split = ~split;
      if ($urandom_range(0, 3) == 0) dig[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
